// File: rtl/cnn_pkg.sv
// Shared datapath types and helpers for the CNN accelerator stages (pooling, conv, fc).
// max2 operates on a wide signed type so lanes of any sample width up to 64 bits can reuse it.
package cnn_pkg;
  localparam int CNN_BITWIDTH = 16;
  localparam int MAX_W        = 64;

  typedef logic signed [CNN_BITWIDTH-1:0] data_t;
  typedef logic signed [MAX_W-1:0]        wide_t;

  function automatic wide_t max2(input wide_t a, input wide_t b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/maxpool_lane.sv
// One channel of the 2x2 max-pool: even-column pair register, half-row line buffer, compare tree.
// MAXPOOL_RELU_EN clamps negative window results to zero without adding latency.
module maxpool_lane
  import cnn_pkg::*;
#(
  parameter int BITWIDTH = 16,
  parameter int WIDTH    = 10,
  parameter int IDX_W    = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       beat,
  input  logic                       col_odd,
  input  logic                       row_odd,
  input  logic [IDX_W-1:0]           idx,
  input  logic signed [BITWIDTH-1:0] in_s,
  output logic signed [BITWIDTH-1:0] result
);
  localparam int ENTRIES = WIDTH / 2;

  logic signed [BITWIDTH-1:0] pair_q, pair_d;
  logic signed [BITWIDTH-1:0] line_q [ENTRIES];
  logic signed [BITWIDTH-1:0] pair_max, win_max;
  logic                       lb_we;

  function automatic logic signed [BITWIDTH-1:0] smax(input logic signed [BITWIDTH-1:0] a,
                                                      input logic signed [BITWIDTH-1:0] b);
    return BITWIDTH'(max2(wide_t'(a), wide_t'(b)));
  endfunction

  always_comb begin
    pair_d   = (beat && !col_odd) ? in_s : pair_q;
    lb_we    = beat && col_odd && !row_odd;
    pair_max = smax(pair_q, in_s);
    win_max  = smax(line_q[idx], pair_max);
`ifdef MAXPOOL_RELU_EN
    if (win_max < 0) win_max = '0;
`endif
    result   = win_max;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pair_q <= '0;
    else        pair_q <= pair_d;
  end

  // Each entry is written on an even row before the odd row reads it, so no reset is needed.
  always_ff @(posedge clk) begin
    if (lb_we) line_q[idx] <= pair_max;
  end
endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 signed max-pool with registered valid/ready output and half-row line buffer.
// Optional fused ReLU when MAXPOOL_RELU_EN is defined (implemented in maxpool_lane).
module maxpool2x2_stream
  import cnn_pkg::*;
#(
  parameter int BITWIDTH = 16,
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 10,
  parameter int HEIGHT   = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*BITWIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*BITWIDTH-1:0] out_data,
  output logic                         out_last
);
  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);
  localparam int IDX_W = (WIDTH >= 4) ? $clog2(WIDTH / 2) : 1;

  if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
    $error("maxpool2x2_stream: WIDTH must be even and >= 2");
  end
  if ((HEIGHT % 2) != 0 || HEIGHT < 2) begin : g_bad_height
    $error("maxpool2x2_stream: HEIGHT must be even and >= 2");
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("maxpool2x2_stream: CHANNELS must be nonzero");
  end

  logic [COL_W-1:0]             col_q, col_d;
  logic [ROW_W-1:0]             row_q, row_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_last_q, out_last_d;
  logic [CHANNELS*BITWIDTH-1:0] out_data_q, out_data_d;
  logic [CHANNELS*BITWIDTH-1:0] result;
  logic [IDX_W-1:0]             idx;
  logic                         in_beat, produce, col_last, row_last;

  // A single rule for every beat: accept whenever the output register is free or draining.
  assign in_ready  = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign idx       = IDX_W'(col_q >> 1);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    maxpool_lane #(
      .BITWIDTH(BITWIDTH),
      .WIDTH   (WIDTH),
      .IDX_W   (IDX_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .beat   (in_beat),
      .col_odd(col_q[0]),
      .row_odd(row_q[0]),
      .idx    (idx),
      .in_s   (in_data[c*BITWIDTH +: BITWIDTH]),
      .result (result[c*BITWIDTH +: BITWIDTH])
    );
  end

  always_comb begin
    in_beat  = in_valid && in_ready;
    col_last = (col_q == COL_W'(WIDTH - 1));
    row_last = (row_q == ROW_W'(HEIGHT - 1));
    produce  = in_beat && row_q[0] && col_q[0];

    col_d = col_q;
    row_d = row_q;
    if (in_beat) begin
      col_d = col_last ? '0 : col_q + COL_W'(1);
      if (col_last) row_d = row_last ? '0 : row_q + ROW_W'(1);
    end

    // Data and last hold while stalled; a new result may reload in the same cycle as an output beat.
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (produce) begin
      out_valid_d = 1'b1;
      out_data_d  = result;
      out_last_d  = row_last && col_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end
endmodule
